// File: rtl/tty_printer_iot.sv
// -----------------------------------------------------------------------------
// tty_printer_iot
//   Console printer device on the CPU IOT bus. Decodes the IOTs addressed to
//   DEVICE and sources SKIP for them. A TPC serialises AC[7:0] as 8N1 on TXD.
//   The printer flag is raised when the stop bit finishes, and it drives IRQ.
//
// Parameters
//   DEVICE  device code compared with IR[8:3]
//   CLKDIV  CLK cycles per serial bit time (>= 2)
//
// Ports
//   CLK    in   system clock, rising edge
//   RESET  in   asynchronous reset, active-high
//   IOT    in   one-cycle strobe, IR holds an IOT being executed
//   IR     in   [11:0] instruction register
//   AC     in   [11:0] accumulator, AC[7:0] is the character
//   SKIP   out  skip request, combinational, valid while IOT=1
//   IRQ    out  interrupt request, level
//   BUSY   out  frame in progress
//   TXD    out  serial data, idles at mark (1)
//
// Build option
//   TTY_IE_EN  adds an interrupt-enable register, which resets to 1.
//              6045 then loads IE from AC[0] and does nothing else.
//              IRQ = flag & IE. Without it, 6045 acts as TSF+TPC.
//
// States
//   ST_IDLE  | line at mark, ready to accept TPC
//   ST_START | start bit (space), one bit time
//   ST_DATA  | eight data bits, LSB first
//   ST_STOP  | stop bit (mark), one bit time; flag is set on its final edge
// -----------------------------------------------------------------------------
module tty_printer_iot #(
  parameter logic [5:0] DEVICE = 6'o04,
  parameter int         CLKDIV = 104
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IOT,
  input  logic [11:0] IR,
  input  logic [11:0] AC,
  output logic        SKIP,
  output logic        IRQ,
  output logic        BUSY,
  output logic        TXD
);

  localparam int            BW       = $clog2(CLKDIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKDIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          txd_q;
  logic          busy_q;
  logic          flag_q;
  logic          flag_d;

  logic sel;
  logic op_set;
  logic op_tsf;
  logic op_tcf;
  logic op_tpc;
  logic op_ie;
  logic frame_end;

  // AC[11:8] has no function in this device.
  logic unused_ac_hi;
  assign unused_ac_hi = ^AC[11:8];

  // ---------------------------------------------------------------------------
  // IOT decode
  // ---------------------------------------------------------------------------
  assign sel = IOT && (IR[11:9] == 3'b110) && (IR[8:3] == DEVICE);

`ifdef TTY_IE_EN
  // 6045 takes over the whole instruction: no skip, no print.
  assign op_ie = sel && (IR[2:0] == 3'b101);
`else
  assign op_ie = 1'b0;
`endif

  assign op_set = sel && (IR[2:0] == 3'b000);
  assign op_tsf = sel && IR[0] && !op_ie;
  assign op_tcf = sel && IR[1] && !op_ie;
  assign op_tpc = sel && IR[2] && !op_ie;

  assign SKIP = op_tsf && flag_q;

  // The last cycle of the stop bit. The edge that ends it sets the flag and
  // returns the FSM to idle together.
  assign frame_end = (state_q == ST_STOP) && (baud_q == '0);

  // ---------------------------------------------------------------------------
  // Printer flag. A set from the frame end wins over a TCF on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    flag_d = flag_q;
    if (frame_end || op_set) begin
      flag_d = 1'b1;
    end else if (op_tcf) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

`ifdef TTY_IE_EN
  logic ie_q;
  logic ie_d;

  always_comb begin
    ie_d = ie_q;
    if (op_ie) begin
      ie_d = AC[0];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ie_q <= 1'b1;
    end else begin
      ie_q <= ie_d;
    end
  end

  assign IRQ = flag_q && ie_q;
`else
  assign IRQ = flag_q;
`endif

  // ---------------------------------------------------------------------------
  // Transmit FSM. The baud counter counts down from CLKDIV-1. On terminal
  // count the FSM moves to the next bit, so every bit lasts exactly CLKDIV
  // cycles. The next data bit is always at shift_q[0].
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_tpc) begin
            shift_q <= AC[7:0];
            baud_q  <= BAUD_MAX;
            bit_q   <= '0;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_START;
          end
        end

        ST_START: begin
          if (baud_q == '0) begin
            baud_q  <= BAUD_MAX;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end

        ST_DATA: begin
          if (baud_q == '0) begin
            baud_q <= BAUD_MAX;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              txd_q   <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end

        ST_STOP: begin
          if (baud_q == '0) begin
            busy_q  <= 1'b0;
            bit_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          baud_q  <= '0;
          bit_q   <= '0;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY = busy_q;
  assign TXD  = txd_q;

endmodule

// File: tb/tb_tty_printer_iot.sv
module tb_tty_printer_iot;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IOT;
  logic [11:0] IR;
  logic [11:0] AC;
  logic        SKIP;
  logic        IRQ;
  logic        BUSY;
  logic        TXD;

  int n_checks = 0;
  int n_fail   = 0;

  tty_printer_iot #(
    .DEVICE(6'o04),
    .CLKDIV(4)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .IOT  (IOT),
    .IR   (IR),
    .AC   (AC),
    .SKIP (SKIP),
    .IRQ  (IRQ),
    .BUSY (BUSY),
    .TXD  (TXD)
  );

  always #5 CLK = ~CLK;

  // The strobe is presented for one rising edge. The task returns at the
  // following falling edge, which is sample s=0 of any frame started here.
  task automatic pulse(input logic [11:0] ir, input logic [11:0] ac);
    IOT = 1'b1; IR = ir; AC = ac;
    @(posedge CLK); #1;
    IOT = 1'b0; IR = 12'o0000; AC = 12'o0000;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1; IOT = 1'b0; IR = 12'o0000; AC = 12'o0000;
    #3;
    n_checks++; if (TXD !== 1'b1)  begin n_fail++; $display("FAIL reset_txd got %b exp 1", TXD); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    n_checks++; if (IRQ !== 1'b0)  begin n_fail++; $display("FAIL reset_irq got %b exp 0", IRQ); end
    n_checks++; if (SKIP !== 1'b0) begin n_fail++; $display("FAIL reset_skip got %b exp 0", SKIP); end
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    n_checks++; if (TXD !== 1'b1 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle got txd=%b busy=%b exp txd=1 busy=0", TXD, BUSY);
    end
  endtask

  // 6046 with AC=0301: char 0xC1, LSB first 1,0,0,0,0,0,1,1
  task automatic test_frame();
    logic [7:0] ch;
    logic       exp_txd;
    logic       exp_busy;
    ch = 8'hC1;
    pulse(12'o6046, 12'o0301);
    for (int s = 0; s <= 40; s++) begin
      exp_txd  = (s < 4) ? 1'b0 : (s < 36) ? ch[3'((s - 4) / 4)] : 1'b1;
      exp_busy = (s < 40);
      n_checks++; if (TXD !== exp_txd) begin
        n_fail++; $display("FAIL frame_txd s=%0d got %b exp %b", s, TXD, exp_txd);
      end
      n_checks++; if (BUSY !== exp_busy) begin
        n_fail++; $display("FAIL frame_busy s=%0d got %b exp %b", s, BUSY, exp_busy);
      end
      if (s >= 39) begin
        n_checks++; if (IRQ !== (s == 40)) begin
          n_fail++; $display("FAIL frame_irq s=%0d got %b exp %b", s, IRQ, (s == 40));
        end
      end
      if (s < 40) @(negedge CLK);
    end
  endtask

  // Entry state: idle, flag=1
  task automatic test_skip();
    IOT = 1'b1; IR = 12'o6041; #1;
    n_checks++; if (SKIP !== 1'b1) begin n_fail++; $display("FAIL tsf_flag_set got %b exp 1", SKIP); end
    IR = 12'o6031; #1;
    n_checks++; if (SKIP !== 1'b0) begin n_fail++; $display("FAIL tsf_other_dev got %b exp 0", SKIP); end
    IOT = 1'b0; IR = 12'o6041; #1;
    n_checks++; if (SKIP !== 1'b0) begin n_fail++; $display("FAIL tsf_no_iot got %b exp 0", SKIP); end
    IR = 12'o0000;
    @(negedge CLK);
    pulse(12'o6042, 12'o0000);
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL tcf_irq got %b exp 0", IRQ); end
    IOT = 1'b1; IR = 12'o6041; #1;
    n_checks++; if (SKIP !== 1'b0) begin n_fail++; $display("FAIL tsf_flag_clr got %b exp 0", SKIP); end
    IOT = 1'b0; IR = 12'o0000;
    @(negedge CLK);
  endtask

  // A TPC during the frame must not disturb it or queue a second frame
  task automatic test_busy_drop();
    logic [7:0] ch;
    logic       exp_txd;
    logic       exp_busy;
    ch = 8'hC1;
    pulse(12'o6046, 12'o0301);
    for (int s = 0; s <= 44; s++) begin
      exp_txd  = (s < 4) ? 1'b0 : (s < 36) ? ch[3'((s - 4) / 4)] : 1'b1;
      exp_busy = (s < 40);
      n_checks++; if (TXD !== exp_txd) begin
        n_fail++; $display("FAIL drop_txd s=%0d got %b exp %b", s, TXD, exp_txd);
      end
      n_checks++; if (BUSY !== exp_busy) begin
        n_fail++; $display("FAIL drop_busy s=%0d got %b exp %b", s, BUSY, exp_busy);
      end
      if (s == 11) begin
        IOT = 1'b1; IR = 12'o6044; AC = 12'o0101;
        @(posedge CLK); #1;
        IOT = 1'b0; IR = 12'o0000; AC = 12'o0000;
      end
      if (s < 44) @(negedge CLK);
    end
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL drop_irq got %b exp 1", IRQ); end
    @(negedge CLK);
  endtask

  task automatic test_frame_end_edge();
    // TCF on the flag-set edge: set wins
    pulse(12'o6046, 12'o0125);
    repeat (39) @(negedge CLK);
    n_checks++; if (BUSY !== 1'b1 || IRQ !== 1'b0) begin
      n_fail++; $display("FAIL tcf_pre_end got busy=%b irq=%b exp busy=1 irq=0", BUSY, IRQ);
    end
    pulse(12'o6042, 12'o0000);
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL tcf_end_irq got %b exp 1", IRQ); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL tcf_end_busy got %b exp 0", BUSY); end

    // TLS on the flag-set edge: char dropped, flag still set
    pulse(12'o6046, 12'o0125);
    repeat (39) @(negedge CLK);
    pulse(12'o6046, 12'o0377);
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL tls_end_irq got %b exp 1", IRQ); end
    n_checks++; if (BUSY !== 1'b0 || TXD !== 1'b1) begin
      n_fail++; $display("FAIL tls_end_drop got busy=%b txd=%b exp busy=0 txd=1", BUSY, TXD);
    end

    // TPC in the cycle right after frame end is accepted; flag untouched
    pulse(12'o6044, 12'o0000);
    n_checks++; if (BUSY !== 1'b1 || TXD !== 1'b0) begin
      n_fail++; $display("FAIL b2b_start got busy=%b txd=%b exp busy=1 txd=0", BUSY, TXD);
    end
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL b2b_irq got %b exp 1", IRQ); end
    repeat (20) @(negedge CLK);
    n_checks++; if (TXD !== 1'b0) begin n_fail++; $display("FAIL b2b_data s=20 got %b exp 0", TXD); end
    repeat (20) @(negedge CLK);
    n_checks++; if (BUSY !== 1'b0 || TXD !== 1'b1) begin
      n_fail++; $display("FAIL b2b_end got busy=%b txd=%b exp busy=0 txd=1", BUSY, TXD);
    end
  endtask

  task automatic test_reset_mid_frame();
    pulse(12'o6042, 12'o0000);
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL set_pre_irq got %b exp 0", IRQ); end
    pulse(12'o6040, 12'o0000);
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL set_6040_irq got %b exp 1", IRQ); end
    // char 0x0F: bit4 is 0, sent at s=20..23
    pulse(12'o6044, 12'o0017);
    repeat (22) @(negedge CLK);
    n_checks++; if (TXD !== 1'b0 || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL mid_data got txd=%b busy=%b exp txd=0 busy=1", TXD, BUSY);
    end
    #2 RESET = 1'b1;
    #1;
    n_checks++; if (TXD !== 1'b1)  begin n_fail++; $display("FAIL async_rst_txd got %b exp 1", TXD); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy got %b exp 0", BUSY); end
    n_checks++; if (IRQ !== 1'b0)  begin n_fail++; $display("FAIL async_rst_irq got %b exp 0", IRQ); end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    pulse(12'o6046, 12'o0017);
    n_checks++; if (TXD !== 1'b0 || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL rst_frame_s0 got txd=%b busy=%b exp txd=0 busy=1", TXD, BUSY);
    end
    repeat (4) @(negedge CLK);
    n_checks++; if (TXD !== 1'b1) begin n_fail++; $display("FAIL rst_frame_s4 got %b exp 1", TXD); end
    repeat (16) @(negedge CLK);
    n_checks++; if (TXD !== 1'b0) begin n_fail++; $display("FAIL rst_frame_s20 got %b exp 0", TXD); end
    repeat (19) @(negedge CLK);
    n_checks++; if (BUSY !== 1'b1 || IRQ !== 1'b0) begin
      n_fail++; $display("FAIL rst_frame_s39 got busy=%b irq=%b exp busy=1 irq=0", BUSY, IRQ);
    end
    @(negedge CLK);
    n_checks++; if (BUSY !== 1'b0 || IRQ !== 1'b1) begin
      n_fail++; $display("FAIL rst_frame_s40 got busy=%b irq=%b exp busy=0 irq=1", BUSY, IRQ);
    end
  endtask

  // Entry state: idle, flag=1, IE=1 (when present)
  task automatic test_6045();
`ifdef TTY_IE_EN
    IOT = 1'b1; IR = 12'o6045; AC = 12'o0000; #1;
    n_checks++; if (SKIP !== 1'b0) begin n_fail++; $display("FAIL ie_skip got %b exp 0", SKIP); end
    @(posedge CLK); #1;
    IOT = 1'b0; IR = 12'o0000; AC = 12'o0000;
    @(negedge CLK);
    n_checks++; if (BUSY !== 1'b0 || IRQ !== 1'b0) begin
      n_fail++; $display("FAIL ie_off got busy=%b irq=%b exp busy=0 irq=0", BUSY, IRQ);
    end
    pulse(12'o6046, 12'o0301);
    repeat (40) @(negedge CLK);
    n_checks++; if (BUSY !== 1'b0 || IRQ !== 1'b0) begin
      n_fail++; $display("FAIL ie_masked got busy=%b irq=%b exp busy=0 irq=0", BUSY, IRQ);
    end
    IOT = 1'b1; IR = 12'o6041; #1;
    n_checks++; if (SKIP !== 1'b1) begin n_fail++; $display("FAIL ie_flag_skip got %b exp 1", SKIP); end
    IOT = 1'b0; IR = 12'o0000;
    @(negedge CLK);
    pulse(12'o6045, 12'o0001);
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL ie_on_irq got %b exp 1", IRQ); end
    n_checks++; if (BUSY !== 1'b0 || TXD !== 1'b1) begin
      n_fail++; $display("FAIL ie_no_frame got busy=%b txd=%b exp busy=0 txd=1", BUSY, TXD);
    end
`else
    IOT = 1'b1; IR = 12'o6045; AC = 12'o0001; #1;
    n_checks++; if (SKIP !== 1'b1) begin n_fail++; $display("FAIL 6045_skip got %b exp 1", SKIP); end
    @(posedge CLK); #1;
    IOT = 1'b0; IR = 12'o0000; AC = 12'o0000;
    @(negedge CLK);
    n_checks++; if (BUSY !== 1'b1 || TXD !== 1'b0) begin
      n_fail++; $display("FAIL 6045_start got busy=%b txd=%b exp busy=1 txd=0", BUSY, TXD);
    end
    repeat (4) @(negedge CLK);
    n_checks++; if (TXD !== 1'b1) begin n_fail++; $display("FAIL 6045_bit0 got %b exp 1", TXD); end
    repeat (36) @(negedge CLK);
    n_checks++; if (BUSY !== 1'b0 || IRQ !== 1'b1) begin
      n_fail++; $display("FAIL 6045_end got busy=%b irq=%b exp busy=0 irq=1", BUSY, IRQ);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_frame();
    test_skip();
    test_busy_drop();
    test_frame_end_edge();
    test_reset_mid_frame();
    test_6045();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "timeout");
  end

endmodule
